// File: rtl/alu_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_acc_pkg
// Purpose  : Shared definitions for the block_alu_acc control sequencer:
//            op_code values, ACC select encodings, FSM state encodings and
//            the packed control word produced by the state decoder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_acc_pkg;

  // op_code values presented by instruction decode
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;

  // ACC high / ACC low select encodings
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  // Sequencer states; codes 11..15 are unreachable and recover to IDLE
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LD_HIGH   = 4'd1,
    ST_LD_LOW    = 4'd2,
    ST_CLR_HIGH  = 4'd3,
    ST_MUL_OP    = 4'd4,
    ST_MUL_SHIFT = 4'd5,
    ST_DIV_SHIFT = 4'd6,
    ST_DIV_OP    = 4'd7,
    ST_DIV_FIX   = 4'd8,
    ST_ALU_OP    = 4'd9,
    ST_DONE      = 4'd10
  } state_t;

  // Control word driven towards block_alu_acc plus status outputs
  typedef struct packed {
    logic       acc_in_select;
    logic [1:0] acc_high_select;
    logic [1:0] acc_low_select;
    logic       acc_high_reset_p;
    logic       op_add;
    logic       op_sub;
    logic       op_mul;
    logic       op_div;
    logic       op_and;
    logic       rd_en;
    logic       busy;
    logic       done;
  } ctrl_word_t;

  // Legal op_codes are the contiguous range ADD..AND
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_AND);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_acc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_acc_sequencer_if
// Purpose  : Bundles the request, flag and control signals exchanged between
//            instruction decode / block_alu_acc and the sequencer.
// Ports    : start, op_code, sign_flag, zero_flag      (towards sequencer)
//            acc_*_select, acc_high_reset_p, op_* strobes, rd_en, busy,
//            done, err, sign_q, zero_q                  (from sequencer)
//            modport slave  : sequencer view
//            modport master : requester / datapath view
// Revision : 1.0 - initial release
// ============================================================================
interface alu_acc_sequencer_if;
  logic       start;
  logic [2:0] op_code;
  logic       sign_flag;
  logic       zero_flag;
  logic       acc_in_select;
  logic [1:0] acc_high_select;
  logic [1:0] acc_low_select;
  logic       acc_high_reset_p;
  logic       op_add;
  logic       op_sub;
  logic       op_mul;
  logic       op_div;
  logic       op_and;
  logic       rd_en;
  logic       busy;
  logic       done;
  logic       err;
  logic       sign_q;
  logic       zero_q;

  modport slave (
    input  start, op_code, sign_flag, zero_flag,
    output acc_in_select, acc_high_select, acc_low_select, acc_high_reset_p,
           op_add, op_sub, op_mul, op_div, op_and,
           rd_en, busy, done, err, sign_q, zero_q
  );

  modport master (
    output start, op_code, sign_flag, zero_flag,
    input  acc_in_select, acc_high_select, acc_low_select, acc_high_reset_p,
           op_add, op_sub, op_mul, op_div, op_and,
           rd_en, busy, done, err, sign_q, zero_q
  );
endinterface
`default_nettype wire

// File: rtl/alu_acc_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_acc_ctrl_decode
// Purpose  : Purely combinational state-to-control-word decoder. Only
//            registered values (state, latched op) feed it, so the control
//            outputs never depend combinationally on sequencer inputs.
// Ports    : i_state - current sequencer state
//            i_op    - op_code latched when start was accepted
//            o_ctrl  - control word for block_alu_acc plus busy/done/rd_en
// Revision : 1.0 - initial release
// ============================================================================
module alu_acc_ctrl_decode
  import alu_acc_pkg::*;
(
  input  state_t     i_state,
  input  logic [2:0] i_op,
  output ctrl_word_t o_ctrl
);

  always_comb begin
    o_ctrl      = '0;
    o_ctrl.busy = 1'b1;
    case (i_state)
      ST_IDLE: begin
        o_ctrl.busy  = 1'b0;
        o_ctrl.rd_en = 1'b1;
      end
      ST_LD_HIGH: begin
        o_ctrl.acc_in_select   = 1'b1;
        o_ctrl.acc_high_select = SEL_LOAD;
      end
      ST_LD_LOW: begin
        o_ctrl.acc_low_select = SEL_LOAD;
      end
      ST_CLR_HIGH: begin
        o_ctrl.acc_high_reset_p = 1'b1;
      end
      ST_MUL_OP: begin
        o_ctrl.op_mul = 1'b1;
      end
      ST_MUL_SHIFT: begin
        o_ctrl.acc_high_select = SEL_SHR;
        o_ctrl.acc_low_select  = SEL_SHR;
      end
      ST_DIV_SHIFT: begin
        o_ctrl.acc_high_select = SEL_SHL;
        o_ctrl.acc_low_select  = SEL_SHL;
      end
      ST_DIV_OP: begin
        o_ctrl.op_div = 1'b1;
      end
      ST_DIV_FIX: begin
        // Only ACC low shifts: pulls the final quotient bit in while the
        // remainder in ACC high stays put.
        o_ctrl.acc_low_select = SEL_SHL;
      end
      ST_ALU_OP: begin
        case (i_op)
          OP_ADD:  o_ctrl.op_add = 1'b1;
          OP_SUB:  o_ctrl.op_sub = 1'b1;
          OP_AND:  o_ctrl.op_and = 1'b1;
          default: o_ctrl.op_add = 1'b0;
        endcase
      end
      ST_DONE: begin
        o_ctrl.done  = 1'b1;
        o_ctrl.rd_en = 1'b1;
      end
      default: begin
        // Unreachable encodings look like IDLE until the FSM recovers
        o_ctrl.busy  = 1'b0;
        o_ctrl.rd_en = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_acc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_acc_sequencer
// Purpose  : Control unit for block_alu_acc. On an accepted start it runs one
//            operation as a fixed micro-op sequence: single-cycle ADD/SUB/AND,
//            shift-add multiply or restoring shift-subtract divide.
// Ports    : clk     - system clock, rising edge
//            reset_n - asynchronous active-low reset
//            bus     - alu_acc_sequencer_if.slave (start/op_code/flags in,
//                      ACC selects, ALU strobes, rd_en/busy/done/err and
//                      captured sign_q/zero_q out)
// Params   : WIDTH - operand width and number of mul/div iterations
//            CNT_W - iteration counter width, 2**CNT_W must exceed WIDTH
// Revision : 1.0 - initial release
// ============================================================================
module alu_acc_sequencer
  import alu_acc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  alu_acc_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

  state_t           r_state;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_sign_q;
  logic             r_zero_q;

  logic [CNT_W-1:0] w_cnt_inc;
  ctrl_word_t       w_ctrl;

  // Saturating increment; the exit test looks at the incremented value so
  // the last iteration leaves straight to DONE / DIV_FIX.
  assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_ADD;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_sign_q <= 1'b0;
      r_zero_q <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_op  <= bus.op_code;
            r_err <= !op_is_legal(bus.op_code);
            case (bus.op_code)
              OP_ADD, OP_SUB, OP_AND: r_state <= ST_ALU_OP;
              OP_MUL, OP_DIV:         r_state <= ST_LD_HIGH;
              default:                r_state <= ST_DONE;
            endcase
          end
        end
        ST_LD_HIGH:  r_state <= ST_LD_LOW;
        ST_LD_LOW:   r_state <= ST_CLR_HIGH;
        ST_CLR_HIGH: begin
          r_cnt   <= '0;
          r_state <= (r_op == OP_MUL) ? ST_MUL_OP : ST_DIV_SHIFT;
        end
        ST_MUL_OP:   r_state <= ST_MUL_SHIFT;
        ST_MUL_SHIFT: begin
          r_cnt   <= w_cnt_inc;
          r_state <= (w_cnt_inc == c_cnt_last) ? ST_DONE : ST_MUL_OP;
        end
        ST_DIV_SHIFT: r_state <= ST_DIV_OP;
        ST_DIV_OP: begin
          r_cnt   <= w_cnt_inc;
          r_state <= (w_cnt_inc == c_cnt_last) ? ST_DIV_FIX : ST_DIV_SHIFT;
        end
        ST_DIV_FIX: r_state <= ST_DONE;
        ST_ALU_OP:  r_state <= ST_DONE;
        ST_DONE: begin
          // Flags reflect the result the ALU presents during DONE
          r_sign_q <= bus.sign_flag;
          r_zero_q <= bus.zero_flag;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  alu_acc_ctrl_decode u_decode (
    .i_state (r_state),
    .i_op    (r_op),
    .o_ctrl  (w_ctrl)
  );

  assign bus.acc_in_select    = w_ctrl.acc_in_select;
  assign bus.acc_high_select  = w_ctrl.acc_high_select;
  assign bus.acc_low_select   = w_ctrl.acc_low_select;
  assign bus.acc_high_reset_p = w_ctrl.acc_high_reset_p;
  assign bus.op_add           = w_ctrl.op_add;
  assign bus.op_sub           = w_ctrl.op_sub;
  assign bus.op_mul           = w_ctrl.op_mul;
  assign bus.op_div           = w_ctrl.op_div;
  assign bus.op_and           = w_ctrl.op_and;
  assign bus.rd_en            = w_ctrl.rd_en;
  assign bus.busy             = w_ctrl.busy;
  assign bus.done             = w_ctrl.done;
  assign bus.err              = r_err;
  assign bus.sign_q           = r_sign_q;
  assign bus.zero_q           = r_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_acc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_acc_sequencer
// Purpose  : Self-checking bench for alu_acc_sequencer. Expected per-cycle
//            control traces are assembled from the operation recipes
//            (load phase, WIDTH iterations, fix-up, DONE) and compared with
//            the DUT outputs one cycle at a time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_acc_sequencer;
  import alu_acc_pkg::*;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_acc_sequencer_if sif ();

  alu_acc_sequencer #(.WIDTH(WIDTH), .CNT_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (sif.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [13:0] exp_q[$];
  logic        m_sign;
  logic        m_zero;

  // Control word layout: {in_sel, high[1:0], low[1:0], clr_high,
  //                       add, sub, mul, div, and, rd_en, busy, done}
  function automatic logic [13:0] cw(input logic in_sel, input logic [1:0] hi,
                                     input logic [1:0] lo, input logic clr,
                                     input logic [4:0] stb, input logic rd,
                                     input logic bsy, input logic dn);
    return {in_sel, hi, lo, clr, stb, rd, bsy, dn};
  endfunction

  function automatic logic [13:0] observed();
    return {sif.acc_in_select, sif.acc_high_select, sif.acc_low_select,
            sif.acc_high_reset_p, sif.op_add, sif.op_sub, sif.op_mul,
            sif.op_div, sif.op_and, sif.rd_en, sif.busy, sif.done};
  endfunction

  logic [13:0] idle_w;
  logic [13:0] done_w;
  assign idle_w = cw(1'b0, 2'b00, 2'b00, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0);
  assign done_w = cw(1'b0, 2'b00, 2'b00, 1'b0, 5'b00000, 1'b1, 1'b1, 1'b1);

  // Operation recipes as a cycle-by-cycle list of control words
  task automatic build_expected(input logic [2:0] op);
    logic [13:0] ld_hi, ld_lo, clr;
    ld_hi = cw(1'b1, 2'b11, 2'b00, 1'b0, 5'b00000, 1'b0, 1'b1, 1'b0);
    ld_lo = cw(1'b0, 2'b00, 2'b11, 1'b0, 5'b00000, 1'b0, 1'b1, 1'b0);
    clr   = cw(1'b0, 2'b00, 2'b00, 1'b1, 5'b00000, 1'b0, 1'b1, 1'b0);
    exp_q.delete();
    case (op)
      3'd0: exp_q.push_back(cw(1'b0, 2'b00, 2'b00, 1'b0, 5'b10000, 1'b0, 1'b1, 1'b0));
      3'd1: exp_q.push_back(cw(1'b0, 2'b00, 2'b00, 1'b0, 5'b01000, 1'b0, 1'b1, 1'b0));
      3'd4: exp_q.push_back(cw(1'b0, 2'b00, 2'b00, 1'b0, 5'b00001, 1'b0, 1'b1, 1'b0));
      3'd2: begin
        exp_q.push_back(ld_hi); exp_q.push_back(ld_lo); exp_q.push_back(clr);
        for (int k = 0; k < WIDTH; k++) begin
          exp_q.push_back(cw(1'b0, 2'b00, 2'b00, 1'b0, 5'b00100, 1'b0, 1'b1, 1'b0));
          exp_q.push_back(cw(1'b0, 2'b01, 2'b01, 1'b0, 5'b00000, 1'b0, 1'b1, 1'b0));
        end
      end
      3'd3: begin
        exp_q.push_back(ld_hi); exp_q.push_back(ld_lo); exp_q.push_back(clr);
        for (int k = 0; k < WIDTH; k++) begin
          exp_q.push_back(cw(1'b0, 2'b10, 2'b10, 1'b0, 5'b00000, 1'b0, 1'b1, 1'b0));
          exp_q.push_back(cw(1'b0, 2'b00, 2'b00, 1'b0, 5'b00010, 1'b0, 1'b1, 1'b0));
        end
        exp_q.push_back(cw(1'b0, 2'b00, 2'b10, 1'b0, 5'b00000, 1'b0, 1'b1, 1'b0));
      end
      default: ;
    endcase
    exp_q.push_back(done_w);
  endtask

  // Runs one operation from IDLE (entered at posedge+1) and returns at
  // posedge+1 of the IDLE cycle that follows DONE. Start pulses are poked
  // into cycles poke_a / poke_b; with chain_next the start is held across
  // DONE->IDLE carrying next_op.
  task automatic run_op(input logic [2:0] op, input int poke_a, input int poke_b,
                        input bit pre_started, input bit chain_next,
                        input logic [2:0] next_op);
    logic exp_err;
    int   n;
    if (!pre_started) begin
      sif.start   = 1'b1;
      sif.op_code = op;
    end
    @(posedge clk); #1;
    sif.start = 1'b0;
    build_expected(op);
    exp_err = !(op <= 3'd4);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (observed() !== exp_q[i]) begin
        failures++;
        $display("FAIL trace op=%0d cycle=%0d got=%h exp=%h", op, i + 1, observed(), exp_q[i]);
      end
      checks++;
      if (sif.err !== exp_err) begin
        failures++;
        $display("FAIL err_in_run op=%0d cycle=%0d got=%b exp=%b", op, i + 1, sif.err, exp_err);
      end
      sif.op_code   = 3'($urandom);
      sif.sign_flag = 1'($urandom);
      sif.zero_flag = 1'($urandom);
      if (exp_q[i][0]) begin
        m_sign = sif.sign_flag;
        m_zero = sif.zero_flag;
      end
      sif.start = ((i + 1) == poke_a) || ((i + 1) == poke_b);
      if (chain_next && (i == n - 1)) begin
        sif.start   = 1'b1;
        sif.op_code = next_op;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (observed() !== idle_w) begin
      failures++;
      $display("FAIL idle_after op=%0d got=%h exp=%h", op, observed(), idle_w);
    end
    checks++;
    if ({sif.err, sif.sign_q, sif.zero_q} !== {exp_err, m_sign, m_zero}) begin
      failures++;
      $display("FAIL status op=%0d got=%b%b%b exp=%b%b%b", op,
               sif.err, sif.sign_q, sif.zero_q, exp_err, m_sign, m_zero);
    end
    if (!chain_next) sif.start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sif.start = 1'b0; sif.op_code = 3'd0;
    sif.sign_flag = 1'b1; sif.zero_flag = 1'b1;
    m_sign = 1'b0; m_zero = 1'b0;
    #12;
    checks++;
    if ({observed(), sif.err, sif.sign_q, sif.zero_q} !== {idle_w, 3'b000}) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", {observed(), sif.err, sif.sign_q, sif.zero_q}, {idle_w, 3'b000});
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (observed() !== idle_w) begin
      failures++;
      $display("FAIL idle_after_reset got=%h exp=%h", observed(), idle_w);
    end
  endtask

  task automatic test_alu();
    run_op(3'd0, 0, 0, 1'b0, 1'b0, 3'd0);
    run_op(3'd1, 0, 0, 1'b0, 1'b0, 3'd0);
    run_op(3'd4, 0, 0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic test_mul_ignored_start();
    // Pulses in cycles 3 and 12 (DONE) must be ignored; op_code churns
    run_op(3'd2, 3, 12, 1'b0, 1'b0, 3'd0);
    // A fresh start afterwards is accepted
    run_op(3'd0, 0, 0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic test_div();
    run_op(3'd3, 5, 13, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic test_illegal();
    run_op(3'd7, 0, 0, 1'b0, 1'b0, 3'd0);
    run_op(3'd5, 1, 0, 1'b0, 1'b0, 3'd0);
    run_op(3'd1, 0, 0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic test_back_to_back();
    run_op(3'd2, 0, 0, 1'b0, 1'b1, 3'd0);
    run_op(3'd0, 0, 0, 1'b1, 1'b1, 3'd3);
    run_op(3'd3, 0, 0, 1'b1, 1'b1, 3'd6);
    run_op(3'd6, 0, 0, 1'b1, 1'b0, 3'd0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      run_op(3'($urandom), int'($urandom_range(0, 14)), int'($urandom_range(0, 14)),
             1'b0, 1'b0, 3'd0);
    end
  endtask

  task automatic test_async_reset();
    sif.start   = 1'b1;
    sif.op_code = 3'd3;
    @(posedge clk); #1;
    sif.start = 1'b0;
    build_expected(3'd3);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (observed() !== exp_q[i]) begin
        failures++;
        $display("FAIL div_before_reset cycle=%0d got=%h exp=%h", i + 1, observed(), exp_q[i]);
      end
      if (i < 5) begin
        @(posedge clk); #1;
      end
    end
    // Mid-cycle 6, away from any clock edge
    #2 reset_n = 1'b0;
    m_sign = 1'b0; m_zero = 1'b0;
    #1;
    checks++;
    if ({observed(), sif.err, sif.sign_q, sif.zero_q} !== {idle_w, 3'b000}) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", {observed(), sif.err, sif.sign_q, sif.zero_q}, {idle_w, 3'b000});
    end
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      checks++;
      if (observed() !== idle_w) begin
        failures++;
        $display("FAIL no_resume cycle=%0d got=%h exp=%h", i, observed(), idle_w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul_ignored_start();
    test_div();
    test_illegal();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_acc_sequencer.md
Name: alu_acc_sequencer

Overview:
- Control unit that drives the control inputs of `block_alu_acc`. It does not touch the datapath.
- On a start request it runs one complete operation as a fixed micro-op sequence: single-cycle ADD/SUB/AND, shift-add multiply, or restoring shift-subtract divide.
- It sits between instruction decode and `block_alu_acc`. It raises `busy` while running and pulses `done` at the end.

Parameters:
- WIDTH, 4: operand width; also the number of mul/div iterations.
- CNT_W, 3: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- op_code  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND; others illegal. Latched when start is accepted.
- sign_flag  in  1  from the ALU.
- zero_flag  in  1  from the ALU.
- acc_in_select  out  1  1 selects the BREG/bus operand as the ACC-high load source.
- acc_high_select  out  2  00 hold, 01 shift right, 10 shift left, 11 load.
- acc_low_select  out  2  00 hold, 01 shift right, 10 shift left, 11 load from ACC high.
- acc_high_reset_p  out  1  clears ACC high; active high, because `block_alu_acc` expects that polarity.
- op_add, op_sub, op_mul, op_div, op_and  out  1 each  one-hot ALU strobes.
- rd_en  out  1  ACC-to-bus read enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  held high when the last op_code was illegal; cleared on the next accepted start.
- sign_q, zero_q  out  1 each  flags captured during the DONE cycle.

Behaviour:
- Outputs form a Moore decode of the state register; there is no combinational path from any input to any output.
- Reset values: state IDLE, counter 0, every output 0 except rd_en = 1.
  - reset_n low mid-operation aborts immediately and asynchronously to these values; there is no resume.
- States and control words:
  - IDLE: all selects 00, all strobes 0, rd_en = 1. start = 1 latches op_code.
    - ADD/SUB/AND go to ALU_OP; MUL/DIV go to LD_HIGH; illegal op_code sets err and goes to DONE.
  - LD_HIGH: acc_in_select = 1, acc_high_select = 11 → LD_LOW.
  - LD_LOW: acc_low_select = 11 → CLR_HIGH.
  - CLR_HIGH: acc_high_reset_p = 1; counter := 0 → MUL_OP or DIV_SHIFT.
  - MUL_OP: op_mul = 1 (the ALU conditionally adds based on ACC LSB) → MUL_SHIFT.
  - MUL_SHIFT: high = 01, low = 01, counter++.
    - If counter reaches WIDTH → DONE; otherwise → MUL_OP.
  - DIV_SHIFT: high = 10, low = 10 → DIV_OP.
  - DIV_OP: op_div = 1 (the ALU restores or loads based on cout), counter++.
    - If counter reaches WIDTH → DIV_FIX; otherwise → DIV_SHIFT.
  - DIV_FIX: low = 10, high = 00. This shifts the last quotient bit into ACC low → DONE.
  - ALU_OP: the matching strobe op_add, op_sub or op_and = 1 for one cycle → DONE.
  - DONE: done = 1, rd_en = 1, sign_q/zero_q captured from sign_flag/zero_flag → IDLE.
- Exactly one of the op_* strobes is high in an op state. A strobe is never high in the same cycle as a non-00 select, apart from the defined shift states.
- Latency from the edge that samples start (state entered in cycle 1):
  - ADD/SUB/AND: ALU_OP in cycle 1, DONE in cycle 2.
  - MUL: load in cycles 1–3, iterations in cycles 4–11, DONE in cycle 12.
  - DIV: load in cycles 1–3, iterations in cycles 4–11, DIV_FIX in cycle 12, DONE in cycle 13.
  - Illegal op_code: DONE in cycle 1.
- A start while busy is ignored, including in the DONE cycle. The op_code is not re-latched.
- A start held high across DONE→IDLE is accepted on the IDLE cycle that follows, giving a back-to-back run.
- The counter saturates. An unreachable state encoding recovers to IDLE on the next edge.

Decomposition:
- Shared package `alu_acc_pkg` holds:
  - op_code constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND);
  - select encodings (SEL_HOLD, SEL_SHR, SEL_SHL, SEL_LOAD);
  - state encodings.
- There is one sub-module, `alu_acc_ctrl_decode`, a purely combinational state-to-control-word decoder. The FSM and counter stay in the top module.

Test Plan:
- MUL 7×2: bench with `block_alu_acc`, bus_data = 0111, bus_reg_data = 0010, op 010 → done in cycle 12, acc_data = 0000_1110; busy high for cycles 1–12.
- DIV 7÷2: same data, op 011 → done in cycle 13, acc_data = 0001_0011 (remainder 1, quotient 3); control-word trace matches the state table cycle by cycle.
- ADD: ACC high preloaded to 0011, BREG = 0010, op 000 → op_add high in cycle 1 only, done in cycle 2, ACC high = 0101, zero_q = 0. SUB 0010−0010 → zero_q = 1.
- start pulses in cycles 3 and 12 of a MUL run → both ignored; op_code change mid-run → no effect; a new start after IDLE is accepted.
- reset_n low in cycle 6 of a DIV run → all outputs return to reset values without waiting for a clock edge; busy = 0; no done pulse.
- op_code 111 → err = 1 and done in cycle 1, no strobes or selects ever asserted; the next legal start clears err.
